// File: rtl/cmp_iter.sv
// Iterative compare unit: resolves all eight funct3 compare/branch conditions
// DIGIT bits per cycle, MSB first, behind valid/ready handshakes on both sides.
module cmp_iter #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             lt,
    output logic             eq
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [KW-1:0]     k_reg;
    logic              found_reg, lt_work_reg;
    logic [WIDTH-1:0]  out_reg;
    logic              lt_reg, eq_reg;

    logic [DIGIT-1:0]  d1, d2;
    logic              diff, last, finish, lt_now, eq_now, res, is_signed;
    logic [WIDTH-1:0]  sign_mask;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_mask = WIDTH'(1) << (WIDTH - 1);
    assign is_signed = (op == 3'b010) || (op == 3'b100) || (op == 3'b101);

    // Operands shift left each cycle, so the current digit is always on top.
    assign d1     = a_reg[WIDTH-1 -: DIGIT];
    assign d2     = b_reg[WIDTH-1 -: DIGIT];
    assign diff   = (d1 != d2);
    assign last   = (k_reg == KW'(N - 1));
    assign finish = last || ((EARLY_EXIT != 0) && diff);

    // The first differing digit decides; later digits cannot override it.
    assign lt_now = found_reg ? lt_work_reg : (diff && (d1 < d2));
    assign eq_now = !found_reg && !diff;

    always_comb begin
        res = lt_now;
        case (op_reg)
            3'b000:         res = eq_now;
            3'b001:         res = !eq_now;
            3'b101, 3'b111: res = !lt_now;
            default:        res = lt_now;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = BUSY;
            BUSY:    if (finish) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            op_reg      <= 3'b000;
            a_reg       <= '0;
            b_reg       <= '0;
            k_reg       <= '0;
            found_reg   <= 1'b0;
            lt_work_reg <= 1'b0;
            out_reg     <= '0;
            lt_reg      <= 1'b0;
            eq_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg      <= op;
                        a_reg       <= x1 ^ (is_signed ? sign_mask : '0);
                        b_reg       <= x2 ^ (is_signed ? sign_mask : '0);
                        k_reg       <= '0;
                        found_reg   <= 1'b0;
                        lt_work_reg <= 1'b0;
                    end
                end
                BUSY: begin
                    a_reg <= a_reg << DIGIT;
                    b_reg <= b_reg << DIGIT;
                    k_reg <= k_reg + KW'(1);
                    if (diff && !found_reg) begin
                        found_reg   <= 1'b1;
                        lt_work_reg <= (d1 < d2);
                    end
                    if (finish) begin
                        out_reg <= WIDTH'(res);
                        lt_reg  <= lt_now;
                        eq_reg  <= eq_now;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out       = out_reg;
    assign lt        = lt_reg;
    assign eq        = eq_reg;
endmodule

// File: doc/cmp_iter.md
# cmp_iter

Iterative, parametrised integer comparator for the datapath ALU. It generalises the single-cycle 32-bit unsigned set-less-than to any `WIDTH` and to all eight RISC-V compare/branch conditions. It resolves `DIGIT` bits per cycle, MSB first, with optional early exit. A valid/ready handshake on both sides lets it serve a multi-cycle execute stage or a low-area branch unit.

## Interface
- `WIDTH`, 32: operand width. Must be a multiple of `DIGIT`.
- `DIGIT`, 4: bits compared per cycle. Number of digits `N = WIDTH/DIGIT`.
- `EARLY_EXIT`, 1: when 1, finish on the first unequal digit. When 0, always scan all `N` digits.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `op`  in  3  condition, using funct3 encoding:
  - 000 EQ, 001 NE, 010 SLT, 011 SLTU
  - 100 LT, 101 GE, 110 LTU, 111 GEU
- `x1`  in  WIDTH  first operand.
- `x2`  in  WIDTH  second operand.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  WIDTH  result, zero-extended: `{WIDTH-1 zeros, res}`.
- `lt`  out  1  raw less-than flag (signedness per `op`).
- `eq`  out  1  raw equality flag.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `op`, `x1`, `x2`, clear digit index `k` to 0, go to BUSY.
- **Signed handling**
  - Signed ops are 010, 100 and 101.
  - For these, invert bit `WIDTH-1` of both latched operands. The rest of the compare is then unsigned.
  - EQ/NE are unaffected by this.
- **BUSY**
  - Each cycle, compare digit `k` of both operands. Digit 0 is bits `[WIDTH-1 : WIDTH-DIGIT]`.
  - First unequal digit: record `lt = (d1 < d2)` and `eq = 0`.
    - If `EARLY_EXIT`=1: go to DONE.
    - Otherwise: keep scanning, but later digits must not change the recorded flags.
  - After digit `N-1`, go to DONE. If no difference was found, `eq`=1 and `lt`=0.
- **Result `res`**
  - 000 → `eq`; 001 → `!eq`.
  - 010, 011, 100, 110 → `lt`.
  - 101, 111 → `!lt`.
- **DONE**
  - `out_valid`=1.
  - `out`, `lt`, `eq` are held stable until `out_valid && out_ready`, then go to IDLE.
- `in_ready`=0 in BUSY and DONE. `in_valid` asserted then is ignored (no queueing).
- **Reset**
  - `rst`=1 at any edge, including mid-BUSY or mid-DONE, goes to IDLE.
  - Reset values: `in_ready`=1, `out_valid`=0, `out`=0, `lt`=0, `eq`=0.
  - A request in flight is discarded.
- `rst` has priority over every other input in the same cycle.

## Timing
- Accept edge is `t0` (`in_valid && in_ready`).
- Digit `i` is examined in cycle `t0+1+i`.
- With early exit at digit `i`, `out_valid` is high from cycle `t0+2+i`.
- Worst case, and every case when `EARLY_EXIT`=0: `out_valid` from `t0+1+N`. For 32/4 this is `t0+9`.
- Minimum latency is 2 cycles (difference in digit 0).
- `out` changes only on the transition into DONE and on reset.
- Throughput: one request per (latency + 1) cycles when `out_ready`=1. The IDLE cycle is mandatory after the handshake.
- `out_valid` never depends combinationally on `out_ready`. `in_ready` is a registered state decode.

## Test plan
All with `WIDTH`=32, `DIGIT`=4, `EARLY_EXIT`=1 unless stated.
- **op=011, x1=10, x2=20:** `out`=1, `lt`=1, `eq`=0. Digits first differ at index 6, so `out_valid` at `t0+8`.
- **op=011, x1=0, x2=FFFFFFFF:** `out`=1 at `t0+2`. Then **op=011, x1=FFFFFFFF, x2=0:** `out`=0 at `t0+2`.
- **Signed vs unsigned, x1=FFFFFFFF, x2=0:**
  - op=010 → `out`=1.
  - op=110 → `out`=0.
  - op=101 → `out`=0.
  - x1=80000000, x2=7FFFFFFF, op=100 → `out`=1.
- **x1=x2=15:**
  - op=000 → 1; op=001 → 0; op=101 → 1; op=011 → 0.
  - All reach `out_valid` at `t0+9` with `eq`=1.
- **Backpressure:** x1=25, x2=5, op=111, with `out_ready`=0 for 5 cycles after `out_valid`.
  - `out`=1 and `out_valid` stay held; `in_ready` stays 0.
  - `in_valid` pulses during the stall are ignored.
  - After `out_ready`=1, one IDLE cycle with `in_ready`=1.
- **Reset and no-early-exit:**
  - Assert `rst` at `t0+3` of a BUSY op: next cycle `in_ready`=1, `out_valid`=0, `out`=0.
  - Rebuild with `EARLY_EXIT`=0, x1=0, x2=FFFFFFFF, op=011: `out`=1 exactly at `t0+9`. The flag is unchanged by later equal digits.
